// File: rtl/epochtv1_vram.sv
// epochtv1_vram: dual byte-bank video RAM responder for the Epoch TV-1 with a zero-fill sweep.
// Ports: CLK clock, RESB sync active-low reset, CE clock enable, CLR clear request, BUSY clear in progress.
//        Bus A (low byte): VAA address, VAD_I/VAD_O data, VAD_OE read valid, nPARD/nPAWR strobes.
//        Bus B (high byte): VBA address, VBD_I/VBD_O data, VBD_OE read valid, nVBRD/nVBWR strobes.
module epochtv1_vram (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        CE,
  input  logic [11:0] VAA,
  input  logic [7:0]  VAD_I,
  output logic [7:0]  VAD_O,
  output logic        VAD_OE,
  input  logic        nPARD,
  input  logic        nPAWR,
  input  logic [11:0] VBA,
  input  logic [7:0]  VBD_I,
  output logic [7:0]  VBD_O,
  output logic        VBD_OE,
  input  logic        nVBRD,
  input  logic        nVBWR,
  input  logic        CLR,
  output logic        BUSY
);
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  state_t      state;
  logic [10:0] ptr;
  logic [7:0]  mem_a [2048];
  logic [7:0]  mem_b [2048];
  logic        pawr_q, vbwr_q;
  logic        ready, wr_a, wr_b, rd_a, rd_b;
  logic        unused_addr_msb;
  // Bit 11 of both address buses is deliberately ignored so the upper half aliases the lower.
  assign unused_addr_msb = VAA[11] ^ VBA[11];
  // A clear request in the same cycle suppresses any strobe.
  assign ready = state == ST_READY && !CLR;
  assign wr_a  = ready && pawr_q && !nPAWR;
  assign wr_b  = ready && vbwr_q && !nVBWR;
  assign rd_a  = ready && !nPARD && nPAWR;
  assign rd_b  = ready && !nVBRD && nVBWR;
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      BUSY   <= 1'b1;
      VAD_O  <= '0;
      VBD_O  <= '0;
      VAD_OE <= 1'b0;
      VBD_OE <= 1'b0;
      pawr_q <= 1'b1;
      vbwr_q <= 1'b1;
    end else if (CE) begin
      pawr_q <= nPAWR;
      vbwr_q <= nVBWR;
      VAD_OE <= rd_a;
      VBD_OE <= rd_b;
      VAD_O  <= rd_a ? mem_a[VAA[10:0]] : VAD_O;
      VBD_O  <= rd_b ? mem_b[VBA[10:0]] : VBD_O;
      if (CLR || (state == ST_CLEAR && ptr != 11'h7ff)) begin
        state <= ST_CLEAR;
        BUSY  <= 1'b1;
        ptr   <= CLR ? 11'd0 : ptr + 11'd1;
      end else begin
        state <= ST_READY;
        BUSY  <= 1'b0;
        ptr   <= '0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RESB && CE) begin
      if (state == ST_CLEAR) begin
        mem_a[ptr] <= '0;
        mem_b[ptr] <= '0;
      end else begin
        if (wr_a) mem_a[VAA[10:0]] <= VAD_I;
        if (wr_b) mem_b[VBA[10:0]] <= VBD_I;
      end
    end
  end
endmodule

// File: tb/tb_epochtv1_vram.sv
// tb_epochtv1_vram: scoreboard bench for epochtv1_vram with directed vectors.
module tb_epochtv1_vram;
  logic        CLK = 1'b0, RESB = 1'b0, CE = 1'b1, CLR = 1'b0;
  logic [11:0] VAA = '0, VBA = '0;
  logic [7:0]  VAD_I = '0, VBD_I = '0;
  logic        nPARD = 1'b1, nPAWR = 1'b1, nVBRD = 1'b1, nVBWR = 1'b1;
  logic [7:0]  VAD_O, VBD_O;
  logic        VAD_OE, VBD_OE, BUSY;
  int          tests = 0, fails = 0;
  logic [7:0]  qa[$], qb[$];

  epochtv1_vram dut (
    .CLK(CLK), .RESB(RESB), .CE(CE),
    .VAA(VAA), .VAD_I(VAD_I), .VAD_O(VAD_O), .VAD_OE(VAD_OE), .nPARD(nPARD), .nPAWR(nPAWR),
    .VBA(VBA), .VBD_I(VBD_I), .VBD_O(VBD_O), .VBD_OE(VBD_OE), .nVBRD(nVBRD), .nVBWR(nVBWR),
    .CLR(CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    logic ce_s;
    @(posedge CLK);
    ce_s = CE;
    #1;
    if (ce_s && RESB) begin
      if (VAD_OE === 1'b1) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_oe: got VAD_OE=1 VAD_O=%0h expected no read", VAD_O);
        end else chk("a_read", VAD_O, qa.pop_front());
      end
      if (VBD_OE === 1'b1) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_oe: got VBD_OE=1 VBD_O=%0h expected no read", VBD_O);
        end else chk("b_read", VBD_O, qb.pop_front());
      end
    end
  end

  task automatic rd_a(input logic [11:0] a, input logic [7:0] e);
    VAA = a; nPARD = 1'b0; qa.push_back(e);
    @(negedge CLK);
    nPARD = 1'b1;
  endtask

  task automatic rd_b(input logic [11:0] a, input logic [7:0] e);
    VBA = a; nVBRD = 1'b0; qb.push_back(e);
    @(negedge CLK);
    nVBRD = 1'b1;
  endtask

  task automatic wr_a(input logic [11:0] a, input logic [7:0] d);
    VAA = a; VAD_I = d; nPAWR = 1'b0;
    @(negedge CLK);
    nPAWR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wr_b(input logic [11:0] a, input logic [7:0] d);
    VBA = a; VBD_I = d; nVBWR = 1'b0;
    @(negedge CLK);
    nVBWR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    RESB = 1'b0;
    @(negedge CLK);
    chk("rst_vad_o", VAD_O, 8'h00);
    chk("rst_vbd_o", VBD_O, 8'h00);
    chk("rst_vad_oe", VAD_OE, 1'b0);
    chk("rst_vbd_oe", VBD_OE, 1'b0);
    chk("rst_busy", BUSY, 1'b1);
    RESB = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk(name, n, 2048);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge CLK);
    reset_pulse();
    wait_ready("busy_len_init");
    // Reset then clear wipes a known non-zero location; first READY cycle strobes are honoured.
    wr_a(12'h005, 8'hA5);
    rd_a(12'h005, 8'hA5);
    reset_pulse();
    wait_ready("busy_len_reset");
    rd_a(12'h005, 8'h00);
    // Held write strobe commits once with the first-cycle data; bit 11 aliases.
    VAA = 12'h123; VAD_I = 8'h5A; nPAWR = 1'b0;
    @(negedge CLK);
    VAD_I = 8'hFF;
    @(negedge CLK);
    @(negedge CLK);
    nPAWR = 1'b1;
    @(negedge CLK);
    rd_a(12'h923, 8'h5A);
    // Bank independence.
    VAA = 12'h010; VAD_I = 8'h11; nPAWR = 1'b0;
    VBA = 12'h010; VBD_I = 8'h22; nVBWR = 1'b0;
    @(negedge CLK);
    nPAWR = 1'b1; nVBWR = 1'b1;
    @(negedge CLK);
    VAA = 12'h010; VBA = 12'h010; nPARD = 1'b0; nVBRD = 1'b0;
    qa.push_back(8'h11); qb.push_back(8'h22);
    @(negedge CLK);
    VAA = 12'h011; VBA = 12'h011;
    qa.push_back(8'h00); qb.push_back(8'h00);
    @(negedge CLK);
    nPARD = 1'b1; nVBRD = 1'b1;
    @(negedge CLK);
    // Streaming read on bus B with a CE gap.
    wr_b(12'h000, 8'h01);
    wr_b(12'h001, 8'h02);
    wr_b(12'h002, 8'h03);
    wr_b(12'h003, 8'h04);
    nVBRD = 1'b0; VBA = 12'h000; qb.push_back(8'h01);
    @(negedge CLK);
    VBA = 12'h001; qb.push_back(8'h02);
    @(negedge CLK);
    CE = 1'b0; VBA = 12'h002;
    @(negedge CLK);
    chk("gap_vbd_o", VBD_O, 8'h02);
    chk("gap_vbd_oe", VBD_OE, 1'b1);
    @(negedge CLK);
    CE = 1'b1; qb.push_back(8'h03);
    @(negedge CLK);
    VBA = 12'h003; qb.push_back(8'h04);
    @(negedge CLK);
    nVBRD = 1'b1;
    @(negedge CLK);
    chk("stream_oe_drop", VBD_OE, 1'b0);
    chk("stream_hold", VBD_O, 8'h04);
    // Both strobes low: write wins, no read.
    VAA = 12'h040; VAD_I = 8'h77; nPARD = 1'b0; nPAWR = 1'b0;
    @(negedge CLK);
    chk("both_oe_1", VAD_OE, 1'b0);
    @(negedge CLK);
    chk("both_oe_2", VAD_OE, 1'b0);
    nPARD = 1'b1; nPAWR = 1'b1;
    @(negedge CLK);
    rd_a(12'h040, 8'h77);
    // CLR is ignored without CE.
    CE = 1'b0; CLR = 1'b1;
    @(negedge CLK);
    CE = 1'b1; CLR = 1'b0;
    @(negedge CLK);
    chk("clr_no_ce_busy", BUSY, 1'b0);
    // CLR with a write: clear wins; restart at pointer 100.
    VAA = 12'h050; VAD_I = 8'h99; nPAWR = 1'b0; CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; nPAWR = 1'b1;
    chk("clr_busy", BUSY, 1'b1);
    repeat (100) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    wait_ready("busy_len_restart");
    rd_a(12'h040, 8'h00);
    // CLR with a read: no OE.
    VAA = 12'h005; nPARD = 1'b0; CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; nPARD = 1'b1;
    chk("clr_rd_oe", VAD_OE, 1'b0);
    chk("clr_rd_busy", BUSY, 1'b1);
    wait_ready("busy_len_clr_rd");
    repeat (3) @(negedge CLK);
    chk("queue_empty", qa.size() + qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
